capture: RTL and testbench
==========================

Name: capture

Overview:
- Pixel capture front end for an 8-bit parallel camera bus (OV7670-style, RGB444 output mode).
- Synchronises to frame boundaries using vsync and samples bytes while href is high.
- Packs each byte pair into one 12-bit RGB444 pixel and writes it to a downstream FIFO through a write strobe with a full back-pressure input.
- Sits between the camera pins (already in the capture clock domain) and the frame-buffer FIFO.

Parameters:
- SKIP_FRAMES, default 0: number of complete frames ignored after reset before pixels are written (camera settling time).

Ports:
- i_clk  input  1  capture clock (camera PCLK domain); all logic on the rising edge.
- i_rstn  input  1  reset; synchronous and active-low.
- i_vsync  input  1  frame sync; high pulse marks the frame boundary.
- i_href  input  1  line valid; high while pixel bytes are present.
- i_data  input  8  camera pixel byte.
- o_wr  output  1  FIFO write strobe; one-cycle pulse per pixel.
- o_wdata  output  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
- i_full  input  1  FIFO full; while high, no write is issued.

Behaviour:
- Clock and reset:
  - Single clock i_clk; reset is synchronous, active-low on i_rstn.
  - Reset values: o_wr=0, o_wdata=0, byte-phase=0, frame counter=0, state=WAIT_VS_HI.
- State machine:
  - WAIT_VS_HI: wait for i_vsync=1, then go to WAIT_VS_LO.
  - WAIT_VS_LO: wait for i_vsync=0, which is frame start.
    - If the skip count is still below SKIP_FRAMES, increment it and return to WAIT_VS_HI.
    - Otherwise go to ACTIVE.
  - ACTIVE: capture bytes. i_vsync=1 ends the frame: go to WAIT_VS_LO, clear byte-phase, and discard any half pixel.
- Byte capture in ACTIVE, sampled on each rising edge with i_href=1:
  - Phase 0 (first byte): latch i_data[3:0] as R; i_data[7:4] is ignored. Toggle phase to 1.
  - Phase 1 (second byte): pixel = {R, i_data[7:0]} (G=i_data[7:4], B=i_data[3:0]). Toggle phase to 0.
  - At the next rising edge, o_wdata=pixel and o_wr=1 for exactly one cycle, unless i_full was 1 at the sampling edge.
- Latency: o_wr is asserted in the cycle immediately after the second byte is sampled. Pixels come out in arrival order.
- Line boundaries: i_href=0 clears byte-phase to 0. A trailing odd byte is discarded, and every line restarts at phase 0.
- Full handling: if i_full=1 when the pixel completes, the pixel is dropped and o_wr stays 0. There is no stall and no retry; the camera cannot be paused.
- Output hold: o_wdata holds its last value while o_wr=0.
- No capture outside ACTIVE: bytes received while waiting for vsync produce no write.
- Reset mid-frame: the machine returns to WAIT_VS_HI, so the next full vsync pulse is needed before capture resumes.
- Simultaneous events: vsync=1 together with a second byte means the pixel is discarded (vsync wins).

Optional Feature:
- Macro CAPTURE_STATS_EN.
- When defined, add output o_frame_cnt[15:0], which increments on each ACTIVE entry and wraps at 0xFFFF→0.
- Also add output o_drop_cnt[15:0], which counts pixels dropped due to i_full and saturates at 0xFFFF.
- Both counters clear on reset.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Reset, then vsync pulse (3 clk high), then href row of 10 bytes alternating F{R} / {GB} -> five o_wr pulses. First byte 0xFA, second 0x5C -> o_wdata=0xA5C one cycle after the second byte.
- Bytes with href=1 before any vsync pulse after reset -> no o_wr.
- Row with odd byte count (3 bytes), then next row 0xF1,0x23 -> exactly 2 writes; second write is 0x123, with no misalignment.
- i_full=1 during the 2nd pixel of a row -> that pixel is absent, neighbours written in order; o_drop_cnt=1 with CAPTURE_STATS_EN.
- vsync rises between the first and second byte -> no write for the half pixel; capture resumes after vsync falls.
- SKIP_FRAMES=2: three frames of 5 rows × 10 bytes -> writes only in the third frame (25 pixels), each matching the randomly generated expected queue.

Source files
------------

// File: rtl/capture.sv
// OV7670-style RGB444 capture: frame sync on vsync, byte pairing under href, FIFO write strobe.
// Optional frame/drop statistics outputs are compiled in with `define CAPTURE_STATS_EN.
module capture #(
  parameter int unsigned SKIP_FRAMES = 0
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_data,
  output logic        o_wr,
  output logic [11:0] o_wdata,
  input  logic        i_full
`ifdef CAPTURE_STATS_EN
  ,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_drop_cnt
`endif
);

  typedef enum logic [1:0] {WAIT_VS_HI, WAIT_VS_LO, ACTIVE} state_t;

  localparam logic [15:0] SKIP_N = 16'(SKIP_FRAMES);

  state_t      state_q;
  logic        phase_q;
  logic [3:0]  red_q;
  logic [15:0] skip_q;
  logic        wr_q;
  logic [11:0] wdata_q;

  logic enter_active_d;
  logic pix_done_d;

  assign enter_active_d = (state_q == WAIT_VS_LO) && !i_vsync && (skip_q == SKIP_N);
  // vsync wins over a completing second byte
  assign pix_done_d     = (state_q == ACTIVE) && !i_vsync && i_href && phase_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= WAIT_VS_HI;
      phase_q <= 1'b0;
      skip_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        WAIT_VS_HI: begin
          if (i_vsync) state_q <= WAIT_VS_LO;
        end
        WAIT_VS_LO: begin
          if (!i_vsync) begin
            if (skip_q != SKIP_N) begin
              skip_q  <= skip_q + 16'd1;
              state_q <= WAIT_VS_HI;
            end else begin
              state_q <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (i_vsync) begin
            state_q <= WAIT_VS_LO;
            phase_q <= 1'b0;
          end else if (!i_href) begin
            phase_q <= 1'b0;
          end else if (!phase_q) begin
            red_q   <= i_data[3:0];
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            if (!i_full) begin
              wr_q    <= 1'b1;
              wdata_q <= {red_q, i_data};
            end
          end
        end
        default: state_q <= WAIT_VS_HI;
      endcase
    end
  end

  assign o_wr    = wr_q;
  assign o_wdata = wdata_q;

`ifdef CAPTURE_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (enter_active_d) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (pix_done_d && i_full && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_capture.sv
// Directed bench for capture: expected pixels (value and arrival cycle) are queued as bytes are driven.
module tb_capture;

  typedef struct {
    logic [11:0] px;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rstn2 = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        full = 1'b0;
  logic        wr1, wr2;
  logic [11:0] wdata1, wdata2;
`ifdef CAPTURE_STATS_EN
  logic [15:0] fc1, dc1, fc2, dc2;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   seen1 = 0, seen2 = 0;
  int   exp_n1 = 0, exp_n2 = 0;
  int   exp_frames = 0, exp_drops = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  logic [11:0] pix_tab [0:15];

  capture #(.SKIP_FRAMES(0)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_vsync(vsync), .i_href(href), .i_data(data),
    .o_wr(wr1), .o_wdata(wdata1), .i_full(full)
`ifdef CAPTURE_STATS_EN
    , .o_frame_cnt(fc1), .o_drop_cnt(dc1)
`endif
  );

  capture #(.SKIP_FRAMES(2)) dut_skip (
    .i_clk(clk), .i_rstn(rstn2), .i_vsync(vsync), .i_href(href), .i_data(data),
    .o_wr(wr2), .o_wdata(wdata2), .i_full(full)
`ifdef CAPTURE_STATS_EN
    , .o_frame_cnt(fc2), .o_drop_cnt(dc2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  // Output monitors: every write must match the head of its queue, including its arrival cycle.
  always @(negedge clk) begin
    if (wr1) begin
      seen1++;
      vectors++;
      if (q1.size() == 0) begin
        miscompares++;
        $error("FAIL dut_write_unexpected got=%03h@%0d expected no write", wdata1, cyc);
      end else begin
        e1 = q1.pop_front();
        assert (wdata1 === e1.px && cyc === e1.cyc) else begin
          miscompares++;
          $error("FAIL dut_pixel got=%03h@%0d expected=%03h@%0d", wdata1, cyc, e1.px, e1.cyc);
        end
      end
    end
    if (wr2) begin
      seen2++;
      vectors++;
      if (q2.size() == 0) begin
        miscompares++;
        $error("FAIL skip_write_unexpected got=%03h@%0d expected no write", wdata2, cyc);
      end else begin
        e2 = q2.pop_front();
        assert (wdata2 === e2.px && cyc === e2.cyc) else begin
          miscompares++;
          $error("FAIL skip_pixel got=%03h@%0d expected=%03h@%0d", wdata2, cyc, e2.px, e2.cyc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic h, input logic [7:0] d, input logic f);
    @(negedge clk);
    vsync = v;
    href  = h;
    data  = d;
    full  = f;
  endtask

  task automatic vs_pulse();
    step(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Drives nb bytes from pix_tab; the pixel with index full_pix completes while full is high.
  task automatic row(input int nb, input int full_pix, input bit p1, input bit p2);
    int          j;
    bit          odd;
    bit          f;
    logic [7:0]  b;
    for (int i = 0; i < nb; i++) begin
      j   = i / 2;
      odd = (i % 2) == 1;
      f   = odd && (j == full_pix);
      b   = odd ? pix_tab[j][7:0] : {4'hF, pix_tab[j][11:8]};
      step(1'b0, 1'b1, b, f);
      if (odd) begin
        if (f) begin
          if (p1) exp_drops++;
        end else begin
          if (p1) begin q1.push_back('{pix_tab[j], cyc + 1}); exp_n1++; end
          if (p2) begin q2.push_back('{pix_tab[j], cyc + 1}); exp_n2++; end
        end
      end
    end
    step(1'b0, 1'b0, 8'($urandom), 1'b0);
    step(1'b0, 1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic rand_tab();
    for (int k = 0; k < 16; k++) pix_tab[k] = 12'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_wr", {31'd0, wr1}, 32'd0);
    chk("reset_wdata", {20'd0, wdata1}, 32'd0);
    rstn = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0);
`ifdef CAPTURE_STATS_EN
    chk("reset_frame_cnt", {16'd0, fc1}, 32'd0);
    chk("reset_drop_cnt", {16'd0, dc1}, 32'd0);
`endif

    // Bytes before any vsync pulse produce nothing.
    rand_tab();
    row(6, -1, 1'b0, 1'b0);
    chk("no_capture_before_vsync", seen1, 32'd0);

    // First frame: five pixels, the first being 0xFA,0x5C -> 0xA5C.
    vs_pulse();
    exp_frames++;
    rand_tab();
    pix_tab[0] = 12'hA5C;
    row(10, -1, 1'b1, 1'b0);
    chk("first_row_writes", seen1, 32'd5);
    chk("wdata_hold", {20'd0, wdata1}, {20'd0, pix_tab[4]});

    // Odd line length, then a fresh line realigned at phase 0.
    rand_tab();
    row(3, -1, 1'b1, 1'b0);
    pix_tab[0] = 12'h123;
    row(2, -1, 1'b1, 1'b0);
    chk("odd_row_writes", seen1, 32'd7);
    chk("odd_row_last", {20'd0, wdata1}, 32'h123);

    // FIFO full on the second pixel of a line.
    rand_tab();
    row(6, 1, 1'b1, 1'b0);
    chk("full_drop_writes", seen1, 32'd9);
`ifdef CAPTURE_STATS_EN
    chk("drop_cnt", {16'd0, dc1}, exp_drops);
`endif

    // vsync arrives with the second byte: half pixel discarded, capture resumes after vsync.
    step(1'b0, 1'b1, 8'hF7, 1'b0);
    step(1'b1, 1'b1, 8'h89, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    exp_frames++;
    chk("vsync_mid_no_write", seen1, 32'd9);
    rand_tab();
    row(4, -1, 1'b1, 1'b0);
    chk("resume_after_vsync", seen1, 32'd11);
`ifdef CAPTURE_STATS_EN
    chk("frame_cnt", {16'd0, fc1}, exp_frames);
`endif

    // Reset mid-frame: nothing is captured until a full vsync pulse.
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_frames = 0;
    exp_drops  = 0;
    chk("reset_mid_wdata", {20'd0, wdata1}, 32'd0);
    rand_tab();
    row(6, -1, 1'b0, 1'b0);
    chk("reset_mid_no_write", seen1, 32'd11);

    // Three frames of 5 lines x 10 bytes; the skipping instance writes only the third.
    rstn2 = 1'b1;
    for (int fr = 0; fr < 3; fr++) begin
      vs_pulse();
      exp_frames++;
      for (int r = 0; r < 5; r++) begin
        rand_tab();
        row(10, -1, 1'b1, fr == 2);
      end
    end
    repeat (4) step(1'b0, 1'b0, 8'h00, 1'b0);

    chk("queue1_drained", q1.size(), 32'd0);
    chk("queue2_drained", q2.size(), 32'd0);
    chk("total_writes_dut", seen1, exp_n1);
    chk("total_writes_skip", seen2, exp_n2);
    chk("skip_writes_25", seen2, 32'd25);
`ifdef CAPTURE_STATS_EN
    chk("frame_cnt_final", {16'd0, fc1}, exp_frames);
    chk("drop_cnt_final", {16'd0, dc1}, exp_drops);
    chk("skip_frame_cnt", {16'd0, fc2}, 32'd1);
    chk("skip_drop_cnt", {16'd0, dc2}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
